// File: rtl/dmem_arb_pkg.sv
// Shared encodings and default sizes for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int MAX_BURST_DEF    = 16;
    localparam int STARVE_LIMIT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CORE      = 2'd1,
        DMA_BURST = 2'd2
    } arb_state_e;

    // Outstanding-read owner: one bit per requester, at most one set at a time.
    typedef struct packed {
        logic dma_rd;
        logic core_rd;
    } owner_t;

endpackage

// File: rtl/dmem_arb_resp_track.sv
// Remembers who issued the read last cycle and steers the 1-cycle read response.
module dmem_arb_resp_track
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic core_rd,
    input  logic dma_rd,
    output logic core_rvalid,
    output logic dma_rvalid
);

    owner_t owner;

    // Async clear drops any pending response so nothing is delivered after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner <= '0;
        end else begin
            owner.core_rd <= core_rd;
            owner.dma_rd  <= dma_rd;
        end
    end

    assign core_rvalid = owner.core_rd;
    assign dma_rvalid  = owner.dma_rd;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the core MEM stage and a DMA requester.
// Optional DMA starvation guard is enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_BURST    = MAX_BURST_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic              stall_m,
    input  logic              dma_req,
    input  logic              dma_lock,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        fsm_state
);

    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    arb_state_e        state, state_next;
    logic [BCNT_W-1:0] burst_cnt, burst_cnt_next;
    logic              starve_force;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
    logic [SCNT_W-1:0] starve_cnt;

    assign starve_force = (starve_cnt == SCNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!dma_req || dma_gnt) begin
            starve_cnt <= '0;
        end else if (!starve_force) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign starve_force        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            burst_cnt <= burst_cnt_next;
        end
    end

    // burst_cnt counts every grant of the locked burst, including the one that opens it.
    always_comb begin
        state_next     = state;
        burst_cnt_next = burst_cnt;
        core_gnt       = 1'b0;
        dma_gnt        = 1'b0;
        if (rst) begin
            case (state)
                IDLE, CORE: begin
                    state_next = IDLE;
                    if (starve_force && dma_req) begin
                        dma_gnt = 1'b1;
                    end else if (core_req) begin
                        core_gnt   = 1'b1;
                        state_next = CORE;
                    end else if (dma_req) begin
                        dma_gnt        = 1'b1;
                        burst_cnt_next = BCNT_W'(1);
                        if (dma_lock && (MAX_BURST > 1)) begin
                            state_next = DMA_BURST;
                        end
                    end
                end
                DMA_BURST: begin
                    if (dma_req) begin
                        dma_gnt        = 1'b1;
                        burst_cnt_next = burst_cnt + 1'b1;
                        if (!dma_lock || (burst_cnt_next == BCNT_W'(MAX_BURST))) begin
                            state_next = IDLE;
                        end
                    end else if (!dma_lock) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign mem_en    = core_gnt | dma_gnt;
    assign stall_m   = core_req & ~core_gnt;
    assign fsm_state = state;

    dmem_arb_resp_track u_resp_track (
        .clk         (clk),
        .rst         (rst),
        .core_rd     (core_gnt & ~core_we),
        .dma_rd      (dma_gnt & ~dma_we),
        .core_rvalid (core_rvalid),
        .dma_rvalid  (dma_rvalid)
    );

    // mem_rdata is steered by the rvalid flags; the arbiter itself never looks at it.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small behavioural memory behind the port.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req, core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt, core_rvalid, stall_m;
    logic              dma_req, dma_lock, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt, dma_rvalid;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        fsm_state;

    int vectors    = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] mem_model [0:255];

    always #5 clk = ~clk;

    // Synchronous single-port memory: word i preloads to 0xA000_0000 | i while in reset.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= 32'hA000_0000 | i;
        end else if (mem_en) begin
            if (mem_we) mem_model[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr[7:0]];
        end
    end

    dmem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .stall_m(stall_m),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fsm_state(fsm_state)
    );

    task automatic idle_inputs();
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dma_req = 1'b0; dma_lock = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_en, mem_we, stall_m} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_en, mem_we, stall_m});
        end
        vectors++;
        if ({mem_addr, mem_wdata} !== 64'h0 || fsm_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_bus: got addr %h wdata %h state %0d want 0 0 0",
                     mem_addr, mem_wdata, fsm_state);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_core_load();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
        @(negedge clk);
        vectors++;
        if ({core_gnt, dma_gnt, mem_en, mem_we, stall_m} !== 5'b10100 || mem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL core_load_issue: got gnt/dgnt/en/we/stall %b addr %h want 10100 10",
                     {core_gnt, dma_gnt, mem_en, mem_we, stall_m}, mem_addr);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (core_rvalid !== 1'b1 || dma_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL core_load_rvalid: got crv %b drv %b en %b want 1 0 0",
                     core_rvalid, dma_rvalid, mem_en);
        end
        vectors++;
        if (mem_rdata !== 32'hA000_0010) begin
            miscompares++;
            $display("FAIL core_load_data: got %h want a0000010", mem_rdata);
        end
        next_cycle();
    endtask

    task automatic test_priority();
        for (int i = 0; i < 5; i++) begin
            core_req = 1'b1; core_we = (i % 2 == 1); core_addr = 32'h20 + i; core_wdata = 32'h1234;
            dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b0; dma_addr = 32'h50;
            @(negedge clk);
            vectors++;
            if ({core_gnt, dma_gnt, stall_m} !== 3'b100 || mem_addr !== 32'h20 + i
                || mem_we !== (i % 2 == 1)) begin
                miscompares++;
                $display("FAIL priority_%0d: got gnt/dgnt/stall %b addr %h we %b want 100 %h %b",
                         i, {core_gnt, dma_gnt, stall_m}, mem_addr, mem_we, 32'h20 + i, i % 2 == 1);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_dma_burst();
        logic exp_dgnt, exp_cgnt, exp_stall, exp_crv;
        for (int k = 1; k <= 20; k++) begin
            dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hD0D0;
            core_req = (k >= 2 && k <= 17); core_we = 1'b0; core_addr = 32'h20;
            exp_dgnt  = (k <= 16) || (k >= 18);
            exp_cgnt  = (k == 17);
            exp_stall = (k >= 2 && k <= 16);
            exp_crv   = (k == 18);
            @(negedge clk);
            vectors++;
            if ({dma_gnt, core_gnt, stall_m, core_rvalid, dma_rvalid}
                !== {exp_dgnt, exp_cgnt, exp_stall, exp_crv, 1'b0}) begin
                miscompares++;
                $display("FAIL burst_k%0d: got dgnt/cgnt/stall/crv/drv %b want %b", k,
                         {dma_gnt, core_gnt, stall_m, core_rvalid, dma_rvalid},
                         {exp_dgnt, exp_cgnt, exp_stall, exp_crv, 1'b0});
            end
            if (k == 18) begin
                vectors++;
                if (mem_rdata !== 32'hA000_0020) begin
                    miscompares++;
                    $display("FAIL burst_core_data: got %h want a0000020", mem_rdata);
                end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        @(negedge clk);
        vectors++;
        if (fsm_state !== 2'd0) begin
            miscompares++;
            $display("FAIL burst_exit_state: got %0d want 0", fsm_state);
        end
        next_cycle();
    endtask

`ifdef DMEM_ARB_STARVE_GUARD_EN
    task automatic test_starve();
        logic exp_dgnt;
        for (int k = 0; k <= 18; k++) begin
            core_req = 1'b1; core_we = 1'b1; core_addr = 32'h24; core_wdata = 32'h77;
            dma_req = 1'b1; dma_lock = 1'b1; dma_we = (k >= 9); dma_addr = 32'h60;
            exp_dgnt = (k == 8) || (k == 17);
            @(negedge clk);
            vectors++;
            if ({dma_gnt, core_gnt, stall_m, dma_rvalid, core_rvalid}
                !== {exp_dgnt, !exp_dgnt, exp_dgnt, k == 9, 1'b0}) begin
                miscompares++;
                $display("FAIL starve_k%0d: got dgnt/cgnt/stall/drv/crv %b want %b", k,
                         {dma_gnt, core_gnt, stall_m, dma_rvalid, core_rvalid},
                         {exp_dgnt, !exp_dgnt, exp_dgnt, k == 9, 1'b0});
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask
`endif

    task automatic test_reset_mid_burst();
        dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b0; dma_addr = 32'h70;
        @(negedge clk);
        vectors++;
        if (dma_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_burst_open: got dgnt %b want 1", dma_gnt);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (dma_gnt !== 1'b1 || fsm_state !== 2'd2 || dma_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_burst_in: got dgnt %b state %0d drv %b want 1 2 1",
                     dma_gnt, fsm_state, dma_rvalid);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        vectors++;
        if ({core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_en} !== 5'b0
            || mem_addr !== '0 || fsm_state !== 2'd0) begin
            miscompares++;
            $display("FAIL rst_burst_async: got flags %b addr %h state %0d want 00000 0 0",
                     {core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_en}, mem_addr, fsm_state);
        end
        next_cycle();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h11;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({core_gnt, dma_gnt, dma_rvalid} !== 3'b100) begin
            miscompares++;
            $display("FAIL rst_release_gnt: got cgnt/dgnt/drv %b want 100",
                     {core_gnt, dma_gnt, dma_rvalid});
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (dma_rvalid !== 1'b0 || core_rvalid !== 1'b1 || mem_rdata !== 32'hA000_0011) begin
            miscompares++;
            $display("FAIL rst_release_resp: got drv %b crv %b data %h want 0 1 a0000011",
                     dma_rvalid, core_rvalid, mem_rdata);
        end
        next_cycle();
    endtask

    task automatic test_dma_write_core_read();
        dma_req = 1'b1; dma_lock = 1'b0; dma_we = 1'b1; dma_addr = 32'h30; dma_wdata = 32'h5A5A_1234;
        @(negedge clk);
        vectors++;
        if ({dma_gnt, core_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 32'h30
            || mem_wdata !== 32'h5A5A_1234) begin
            miscompares++;
            $display("FAIL wr_rd_dma: got flags %b addr %h wdata %h want 1011 30 5a5a1234",
                     {dma_gnt, core_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        next_cycle();
        idle_inputs();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h30;
        @(negedge clk);
        vectors++;
        if ({core_gnt, mem_we, dma_rvalid} !== 3'b100) begin
            miscompares++;
            $display("FAIL wr_rd_core: got cgnt/we/drv %b want 100", {core_gnt, mem_we, dma_rvalid});
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (core_rvalid !== 1'b1 || mem_rdata !== 32'h5A5A_1234) begin
            miscompares++;
            $display("FAIL wr_rd_data: got crv %b data %h want 1 5a5a1234", core_rvalid, mem_rdata);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h21;
        @(negedge clk);
        vectors++;
        if (core_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_core: got cgnt %b dgnt %b want 1 0", core_gnt, dma_gnt);
        end
        next_cycle();
        idle_inputs();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h22;
        @(negedge clk);
        vectors++;
        if ({dma_gnt, core_rvalid, dma_rvalid} !== 3'b110 || mem_rdata !== 32'hA000_0021) begin
            miscompares++;
            $display("FAIL b2b_dma: got dgnt/crv/drv %b data %h want 110 a0000021",
                     {dma_gnt, core_rvalid, dma_rvalid}, mem_rdata);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if ({core_rvalid, dma_rvalid} !== 2'b01 || mem_rdata !== 32'hA000_0022) begin
            miscompares++;
            $display("FAIL b2b_resp: got crv/drv %b data %h want 01 a0000022",
                     {core_rvalid, dma_rvalid}, mem_rdata);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_core_load();
        test_priority();
        test_dma_burst();
`ifdef DMEM_ARB_STARVE_GUARD_EN
        test_starve();
`endif
        test_reset_mid_burst();
        test_dma_write_core_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
